// File: rtl/pedal_sensor_cond.sv
// rtl/pedal_sensor_cond.sv - crank cadence debounce/window count and exponential torque average
module pedal_sensor_cond #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence_raw,
    input  logic [11:0] torque,
    input  logic        torque_vld,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling
);

    localparam int WIN_W = FAST_SIM ? 12 : 22;
    localparam logic [WIN_W-1:0] WIN_INC = {{(WIN_W-1){1'b0}}, 1'b1};

    logic             sync0_q, sync1_q;
    logic             cad_filt_q, cad_filt_d;
    logic [3:0]       db_cnt_q, db_cnt_d;
    logic [4:0]       edge_cnt_q, edge_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [4:0]       cadence_q, cadence_d;
    logic             not_ped_q, not_ped_d;
    logic [16:0]      accum_q, accum_d;

    logic             mismatch, db_done, rise, win_tc;
    logic [4:0]       edge_inc;

    always_comb begin
        mismatch   = sync1_q ^ cad_filt_q;
        db_done    = mismatch && (db_cnt_q == 4'hF);
        cad_filt_d = db_done ? sync1_q : cad_filt_q;
        db_cnt_d   = (mismatch && !db_done) ? db_cnt_q + 4'd1 : 4'd0;
        rise       = db_done && sync1_q;
        edge_inc   = (rise && (edge_cnt_q != 5'd31)) ? edge_cnt_q + 5'd1 : edge_cnt_q;

        // An edge landing on terminal count is folded into the closing window only.
        win_tc     = &win_cnt_q;
        win_cnt_d  = win_cnt_q + WIN_INC;
        edge_cnt_d = win_tc ? 5'd0 : edge_inc;
        cadence_d  = win_tc ? edge_inc : cadence_q;
        not_ped_d  = win_tc ? (edge_inc < 5'd2) : not_ped_q;

        accum_d = accum_q;
        if (torque_vld) begin
            accum_d = accum_q - {5'd0, accum_q[16:5]} + {5'd0, torque};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            cad_filt_q <= 1'b0;
            db_cnt_q   <= 4'd0;
            edge_cnt_q <= 5'd0;
            win_cnt_q  <= '0;
            cadence_q  <= 5'd0;
            not_ped_q  <= 1'b1;
            accum_q    <= 17'd0;
        end else begin
            sync0_q    <= cadence_raw;
            sync1_q    <= sync0_q;
            cad_filt_q <= cad_filt_d;
            db_cnt_q   <= db_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            win_cnt_q  <= win_cnt_d;
            cadence_q  <= cadence_d;
            not_ped_q  <= not_ped_d;
            accum_q    <= accum_d;
        end
    end

    assign avg_torque   = accum_q[16:5];
    assign cadence      = cadence_q;
    assign not_pedaling = not_ped_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// tb/tb_pedal_sensor_cond.sv - self-checking bench for pedal_sensor_cond
module tb_pedal_sensor_cond;

    localparam int WIN = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cadence_raw = 1'b0;
    logic [11:0] torque = 12'd0;
    logic        torque_vld = 1'b0;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int exp_cnt[int];
    int model_accum;

    pedal_sensor_cond #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_raw  (cadence_raw),
        .torque       (torque),
        .torque_vld   (torque_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling)
    );

    always #5 clk = ~clk;

    // Edge index since reset release; window w closes on edge w*WIN.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cadence_raw = 1'b0;
        torque_vld = 1'b0;
        torque = 12'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt.delete();
        model_accum = 0;
    endtask

    task automatic wait_cyc(input int target);
        int g;
        g = 0;
        while (cyc < target && g < 3 * WIN) begin
            @(negedge clk);
            g++;
        end
        if (cyc != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, target);
        end
    endtask

    // A clean rising edge reaches the counter 18 edges after the raw change is sampled.
    function automatic void note_edge(input int e);
        int w;
        w = (e + WIN - 1) / WIN;
        if (exp_cnt.exists(w)) exp_cnt[w] = exp_cnt[w] + 1;
        else exp_cnt[w] = 1;
    endfunction

    function automatic int exp_window(input int w);
        int e;
        e = exp_cnt.exists(w) ? exp_cnt[w] : 0;
        return (e > 31) ? 31 : e;
    endfunction

    task automatic drive_pulse(input int hi, input int lo);
        cadence_raw = 1'b1;
        if (hi >= 16) note_edge(cyc + 18);
        repeat (hi) @(negedge clk);
        cadence_raw = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic strobe(input logic [11:0] t, input logic v);
        torque = t;
        torque_vld = v;
        @(negedge clk);
        if (v) model_accum = model_accum - model_accum / 32 + int'(t);
    endtask

    task automatic test_reset();
        int e;
        do_reset();
        torque = 12'($urandom);
        torque_vld = 1'b1;
        wait_cyc(64);
        repeat (3) drive_pulse(64, 64);
        torque_vld = 1'b0;
        wait_cyc(WIN);
        e = exp_window(1);
        n_checks++;
        if (cadence !== 5'd3 || e != 3) begin
            n_fail++;
            $display("FAIL rst_pre_window: cadence=%0d model=%0d required 3", cadence, e);
        end
        torque_vld = 1'b1;
        torque = 12'hABC;
        repeat (2) drive_pulse(64, 64);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (avg_torque !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_async_avg: got %h required 000", avg_torque);
        end
        n_checks++;
        if (cadence !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_async_cadence: got %0d required 0", cadence);
        end
        n_checks++;
        if (not_pedaling !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async_notped: got %b required 1", not_pedaling);
        end
        torque_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt.delete();
        model_accum = 0;
        wait_cyc(64);
        repeat (3) drive_pulse(64, 64);
        wait_cyc(WIN - 1);
        n_checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1 || avg_torque !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_hold: cadence=%0d notped=%b avg=%h required 0/1/000",
                     cadence, not_pedaling, avg_torque);
        end
        wait_cyc(WIN);
        e = exp_window(1);
        n_checks++;
        if (cadence !== e[4:0] || not_pedaling !== (e < 2)) begin
            n_fail++;
            $display("FAIL rst_first_window: cadence=%0d notped=%b required %0d/%b",
                     cadence, not_pedaling, e, (e < 2));
        end
    endtask

    task automatic test_torque_converge();
        do_reset();
        for (int i = 1; i <= 600; i++) begin
            strobe(12'h800, 1'b1);
            n_checks++;
            if (avg_torque !== 12'(model_accum / 32)) begin
                n_fail++;
                $display("FAIL conv_model[%0d]: got %h required %h", i, avg_torque, model_accum / 32);
            end
            if (i == 1) begin
                n_checks++;
                if (avg_torque !== 12'h040) begin
                    n_fail++;
                    $display("FAIL conv_first: got %h required 040", avg_torque);
                end
            end
            if (i >= 512) begin
                n_checks++;
                if (avg_torque !== 12'h800) begin
                    n_fail++;
                    $display("FAIL conv_settled[%0d]: got %h required 800", i, avg_torque);
                end
            end
        end
        torque_vld = 1'b0;
    endtask

    task automatic test_torque_max();
        logic [11:0] prev;
        do_reset();
        for (int i = 1; i <= 1024; i++) begin
            strobe(12'hFFF, 1'b1);
            n_checks++;
            if (avg_torque !== 12'(model_accum / 32)) begin
                n_fail++;
                $display("FAIL max_rise[%0d]: got %h required %h", i, avg_torque, model_accum / 32);
            end
        end
        n_checks++;
        if (avg_torque !== 12'hFFF) begin
            n_fail++;
            $display("FAIL max_top: got %h required fff", avg_torque);
        end
        prev = avg_torque;
        for (int i = 1; i <= 1024; i++) begin
            strobe(12'h000, 1'b1);
            n_checks++;
            if (avg_torque > prev || avg_torque !== 12'(model_accum / 32)) begin
                n_fail++;
                $display("FAIL max_decay[%0d]: got %h prev %h required %h",
                         i, avg_torque, prev, model_accum / 32);
            end
            prev = avg_torque;
        end
        n_checks++;
        if (avg_torque !== 12'h000) begin
            n_fail++;
            $display("FAIL max_floor: got %h required 000", avg_torque);
        end
        torque_vld = 1'b0;
    endtask

    task automatic test_torque_random();
        for (int i = 0; i < 400; i++) begin
            strobe(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (avg_torque !== 12'(model_accum / 32)) begin
                n_fail++;
                $display("FAIL rand_torque[%0d]: got %h required %h", i, avg_torque, model_accum / 32);
            end
        end
        torque_vld = 1'b0;
    endtask

    task automatic test_normal_cadence();
        do_reset();
        wait_cyc(64);
        repeat (10) drive_pulse(64, 64);
        wait_cyc(WIN);
        n_checks++;
        if (cadence !== 5'd10 || not_pedaling !== 1'b0 || exp_window(1) != 10) begin
            n_fail++;
            $display("FAIL normal_w1: cadence=%0d notped=%b required 10/0", cadence, not_pedaling);
        end
        wait_cyc(2 * WIN);
        n_checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_idle: cadence=%0d notped=%b required 0/1", cadence, not_pedaling);
        end
    endtask

    task automatic test_saturation();
        wait_cyc(2 * WIN + 64);
        repeat (40) drive_pulse(25, 25);
        wait_cyc(3 * WIN);
        n_checks++;
        if (cadence !== 5'd31 || not_pedaling !== 1'b0) begin
            n_fail++;
            $display("FAIL sat: cadence=%0d notped=%b required 31/0", cadence, not_pedaling);
        end
        wait_cyc(3 * WIN + 64);
        repeat (20) drive_pulse(8, 40);
        wait_cyc(4 * WIN);
        n_checks++;
        if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce: cadence=%0d notped=%b required 0/1", cadence, not_pedaling);
        end
    endtask

    task automatic test_debounce_boundary();
        wait_cyc(4 * WIN + 64);
        repeat (5) drive_pulse(15, 40);
        repeat (3) drive_pulse(16, 40);
        wait_cyc(5 * WIN);
        n_checks++;
        if (cadence !== 5'd3 || not_pedaling !== 1'b0) begin
            n_fail++;
            $display("FAIL db_boundary: cadence=%0d notped=%b required 3/0", cadence, not_pedaling);
        end
    endtask

    task automatic test_random_cadence();
        int n, e;
        for (int w = 6; w <= 8; w++) begin
            wait_cyc((w - 1) * WIN + 40);
            n = $urandom_range(0, 35);
            for (int p = 0; p < n; p++) begin
                drive_pulse($urandom_range(10, 40), $urandom_range(16, 40));
            end
            wait_cyc(w * WIN);
            e = exp_window(w);
            n_checks++;
            if (cadence !== e[4:0] || not_pedaling !== (e < 2)) begin
                n_fail++;
                $display("FAIL rand_cad_w%0d: cadence=%0d notped=%b required %0d/%b",
                         w, cadence, not_pedaling, e, (e < 2));
            end
        end
    endtask

    task automatic test_edge_on_tc();
        int e;
        wait_cyc(8 * WIN + 64);
        repeat (4) drive_pulse(64, 64);
        wait_cyc(9 * WIN - 18);
        cadence_raw = 1'b1;
        note_edge(cyc + 18);
        wait_cyc(9 * WIN);
        e = exp_window(9);
        n_checks++;
        if (cadence !== 5'd5 || not_pedaling !== 1'b0 || e != 5) begin
            n_fail++;
            $display("FAIL tc_edge: cadence=%0d notped=%b model=%0d required 5/0",
                     cadence, not_pedaling, e);
        end
        repeat (46) @(negedge clk);
        cadence_raw = 1'b0;
        repeat (64) @(negedge clk);
        repeat (3) drive_pulse(64, 64);
        wait_cyc(10 * WIN);
        e = exp_window(10);
        n_checks++;
        if (cadence !== 5'd3 || not_pedaling !== 1'b0 || e != 3) begin
            n_fail++;
            $display("FAIL tc_next: cadence=%0d notped=%b model=%0d required 3/0",
                     cadence, not_pedaling, e);
        end
    endtask

    initial begin
        test_reset();
        test_torque_converge();
        test_torque_max();
        test_torque_random();
        test_normal_cadence();
        test_saturation();
        test_debounce_boundary();
        test_random_cadence();
        test_edge_on_tc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
